// File: rtl/count_capture.sv
// rtl/count_capture.sv - edge-triggered counter snapshot into a FWFT FIFO with drop tracking
module count_capture #(
   parameter int CW    = 32,
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CW-1:0]            count_in,
   input  logic                     evt_in,
   input  logic [1:0]               edge_sel,
   output logic [CW-1:0]            ts_data,
   output logic                     ts_valid,
   input  logic                     ts_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [DW-1:0]            drop_cnt,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [DW-1:0] DROP_MAX = {DW{1'b1}};

   logic [CW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          armed;
   logic          evt_d;
   logic          rise;
   logic          fall;
   logic          hit;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   // armed gates the first post-reset cycle so a high evt_in is not seen as an edge
   assign rise = evt_in & ~evt_d;
   assign fall = ~evt_in & evt_d;
   assign hit  = armed & ((edge_sel[0] & rise) | (edge_sel[1] & fall));

   assign ts_valid = (level != '0);
   assign ts_data  = mem[rd_ptr];
   assign full     = (level == FULL_LVL);
   assign pop      = ts_valid & ts_ready;
   assign push     = hit & (~full | pop);
   assign drop     = hit & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         armed    <= 1'b0;
         evt_d    <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         armed <= 1'b1;
         evt_d <= evt_in;

         if (push) begin
            mem[wr_ptr] <= count_in;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         if (push & ~pop) begin
            level <= level + LW'(1);
         end else if (pop & ~push) begin
            level <= level - LW'(1);
         end

         // a drop in the same cycle as clr_ovf restarts the count at one
         if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
               drop_cnt <= DW'(1);
            end else if (drop_cnt != DROP_MAX) begin
               drop_cnt <= drop_cnt + DW'(1);
            end
         end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_count_capture.sv
// tb/tb_count_capture.sv - directed vector table plus hand sequences for count_capture
module tb_count_capture;

   logic        clk;
   logic        rst;
   logic [31:0] count_in;
   logic        evt_in;
   logic [1:0]  edge_sel;
   logic [31:0] ts_data;
   logic        ts_valid;
   logic        ts_ready;
   logic [2:0]  level;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clr_ovf;

   int total;
   int bad;

   count_capture #(.CW(32), .DEPTH(4), .DW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .count_in (count_in),
      .evt_in   (evt_in),
      .edge_sel (edge_sel),
      .ts_data  (ts_data),
      .ts_valid (ts_valid),
      .ts_ready (ts_ready),
      .level    (level),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .clr_ovf  (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] cnt;
      logic        evt;
      logic [1:0]  es;
      logic        rdy;
      logic        v;
      logic [31:0] d;
      logic [2:0]  lvl;
   } vec_t;

   vec_t tbl [26];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] c, input logic e, input logic [1:0] s,
                        input logic r, input logic k);
      count_in = c;
      evt_in   = e;
      edge_sel = s;
      ts_ready = r;
      clr_ovf  = k;
      tick();
   endtask

   logic [31:0] exp_q [$];

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; count_in = '0; evt_in = 1'b1; edge_sel = 2'b01; ts_ready = 1'b0; clr_ovf = 1'b0;

      // rst, cnt, evt, es, rdy | valid, data, level
      tbl[0]  = '{1'b1, 32'h00, 1'b1, 2'b01, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[1]  = '{1'b0, 32'h01, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[2]  = '{1'b0, 32'h02, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[3]  = '{1'b0, 32'h03, 1'b0, 2'b01, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[4]  = '{1'b0, 32'h10, 1'b1, 2'b01, 1'b0, 1'b1, 32'h10, 3'd1};
      tbl[5]  = '{1'b0, 32'h11, 1'b1, 2'b01, 1'b1, 1'b0, 32'h00, 3'd0};
      tbl[6]  = '{1'b0, 32'h14, 1'b0, 2'b01, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[7]  = '{1'b0, 32'h15, 1'b0, 2'b01, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[8]  = '{1'b0, 32'h20, 1'b1, 2'b11, 1'b0, 1'b1, 32'h20, 3'd1};
      tbl[9]  = '{1'b0, 32'h21, 1'b1, 2'b11, 1'b0, 1'b1, 32'h20, 3'd1};
      tbl[10] = '{1'b0, 32'h22, 1'b1, 2'b11, 1'b0, 1'b1, 32'h20, 3'd1};
      tbl[11] = '{1'b0, 32'h23, 1'b0, 2'b11, 1'b0, 1'b1, 32'h20, 3'd2};
      tbl[12] = '{1'b0, 32'h26, 1'b0, 2'b11, 1'b0, 1'b1, 32'h20, 3'd2};
      tbl[13] = '{1'b0, 32'h27, 1'b1, 2'b11, 1'b0, 1'b1, 32'h20, 3'd3};
      tbl[14] = '{1'b0, 32'h28, 1'b1, 2'b11, 1'b1, 1'b1, 32'h23, 3'd2};
      tbl[15] = '{1'b0, 32'h29, 1'b1, 2'b11, 1'b1, 1'b1, 32'h27, 3'd1};
      tbl[16] = '{1'b0, 32'h2a, 1'b1, 2'b11, 1'b1, 1'b0, 32'h00, 3'd0};
      tbl[17] = '{1'b0, 32'h2b, 1'b1, 2'b11, 1'b1, 1'b0, 32'h00, 3'd0};
      tbl[18] = '{1'b0, 32'h30, 1'b0, 2'b11, 1'b0, 1'b1, 32'h30, 3'd1};
      tbl[19] = '{1'b0, 32'h31, 1'b1, 2'b11, 1'b0, 1'b1, 32'h30, 3'd2};
      tbl[20] = '{1'b0, 32'h32, 1'b0, 2'b11, 1'b0, 1'b1, 32'h30, 3'd3};
      tbl[21] = '{1'b1, 32'h33, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[22] = '{1'b0, 32'h34, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[23] = '{1'b0, 32'h35, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00, 3'd0};
      tbl[24] = '{1'b0, 32'h36, 1'b0, 2'b11, 1'b1, 1'b1, 32'h36, 3'd1};
      tbl[25] = '{1'b0, 32'h37, 1'b0, 2'b11, 1'b1, 1'b0, 32'h00, 3'd0};

      for (int i = 0; i < 26; i++) begin
         rst = tbl[i].rst;
         drive(tbl[i].cnt, tbl[i].evt, tbl[i].es, tbl[i].rdy, 1'b0);
         chk($sformatf("vec%0d_valid", i), 32'(ts_valid), 32'(tbl[i].v));
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
         chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'd0);
         if (tbl[i].v) chk($sformatf("vec%0d_data", i), ts_data, tbl[i].d);
      end

      // overflow: six rising edges into a depth-4 FIFO, nothing consumed
      for (int i = 0; i < 6; i++) begin
         drive(32'h40 + 32'(2 * i), 1'b1, 2'b01, 1'b0, 1'b0);
         drive(32'h41 + 32'(2 * i), 1'b0, 2'b01, 1'b0, 1'b0);
      end
      chk("ovf_level", 32'(level), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      chk("ovf_head", ts_data, 32'h40);
      drive(32'h4c, 1'b1, 2'b01, 1'b0, 1'b1);
      chk("clr_drop_flag", 32'(overflow), 32'd1);
      chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
      drive(32'h4d, 1'b0, 2'b01, 1'b0, 1'b1);
      chk("clr_only_flag", 32'(overflow), 32'd0);
      chk("clr_only_cnt", 32'(drop_cnt), 32'd0);

      // full with simultaneous pop and push
      drive(32'h50, 1'b1, 2'b01, 1'b1, 1'b0);
      chk("fullpp_level", 32'(level), 32'd4);
      chk("fullpp_drop", 32'(drop_cnt), 32'd0);
      chk("fullpp_flag", 32'(overflow), 32'd0);
      exp_q = '{32'h42, 32'h44, 32'h46, 32'h50};
      foreach (exp_q[k]) begin
         chk($sformatf("fullpp_valid%0d", k), 32'(ts_valid), 32'd1);
         chk($sformatf("fullpp_data%0d", k), ts_data, exp_q[k]);
         drive(32'h51, 1'b1, 2'b01, 1'b1, 1'b0);
      end
      chk("fullpp_empty", 32'(ts_valid), 32'd0);

      // drop counter saturation: 4 pushes then 266 drops
      for (int i = 0; i < 270; i++) begin
         drive(32'h100 + 32'(i), (i % 2) == 0 ? 1'b0 : 1'b1, 2'b11, 1'b0, 1'b0);
      end
      chk("sat_drop", 32'(drop_cnt), 32'hff);
      chk("sat_level", 32'(level), 32'd4);
      chk("sat_head", ts_data, 32'h100);
      for (int i = 0; i < 5; i++) drive(32'h200, 1'b1, 2'b00, 1'b1, 1'b1);
      chk("sat_clr", 32'(drop_cnt), 32'd0);
      chk("sat_drained", 32'(level), 32'd0);

      // counter wrap with both edges, then the same stimulus with edges disabled
      drive(32'hFFFF_FFFD, 1'b0, 2'b00, 1'b0, 1'b0);
      drive(32'hFFFF_FFFE, 1'b1, 2'b11, 1'b0, 1'b0);
      drive(32'hFFFF_FFFF, 1'b0, 2'b11, 1'b0, 1'b0);
      drive(32'h0000_0000, 1'b1, 2'b11, 1'b0, 1'b0);
      chk("wrap_level", 32'(level), 32'd3);
      exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
      foreach (exp_q[k]) begin
         chk($sformatf("wrap_data%0d", k), ts_data, exp_q[k]);
         drive(32'h1, 1'b1, 2'b00, 1'b1, 1'b0);
      end
      chk("wrap_empty", 32'(ts_valid), 32'd0);
      drive(32'hFFFF_FFFE, 1'b0, 2'b00, 1'b0, 1'b0);
      drive(32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 1'b0);
      drive(32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("none_level", 32'(level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
